// File: rtl/zood_round_controller.sv
// zood_round_controller
// Builds a guess one shape at a time and sends it to the Zood checker.
// Captures the returned Zood count and counts rounds.
// Declares a win when Zood equals NUM_SLOTS, or a loss when the round budget runs out.
// Optional build macro AUTO_CLEAR_GUESS_EN: when it is defined, the guess register
// clears on the result cycle of every round that returns to ENTRY.
module zood_round_controller #(
    parameter int NUM_SLOTS  = 4,
    parameter int MAX_ROUNDS = 8,
    parameter int CHECK_LAT  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   masterLoaded,
    input  logic [2:0]             guessShape,
    input  logic [1:0]             guessLocation,
    input  logic                   loadGuess,
    input  logic                   submitGuess,
    input  logic [3:0]             Zood,
    output logic [NUM_SLOTS*3-1:0] guess,
    output logic                   check,
    output logic [3:0]             roundNumber,
    output logic [3:0]             lastZood,
    output logic                   resultValid,
    output logic                   gameWon,
    output logic                   gameLost,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        WAIT,
        DONE
    } roundState_t;

    roundState_t state;
    logic [2:0]  waitCount;

    logic [NUM_SLOTS*3-1:0] loadedGuess;
    logic                   guessComplete;

    // Apply this cycle's load first, so that a submit in the same cycle sees the updated guess
    always_comb begin
        loadedGuess   = guess;
        guessComplete = 1'b1;
        if (loadGuess && (guessShape != 3'b000) && (guessShape != 3'b111)
            && (int'(guessLocation) < NUM_SLOTS)) begin
            loadedGuess[int'(guessLocation)*3 +: 3] = guessShape;
        end
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (loadedGuess[k*3 +: 3] == 3'b000) begin
                guessComplete = 1'b0;
            end
        end
    end

    // Round sequencer; all outputs are registered here so the checker sees clean pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            waitCount   <= '0;
            guess       <= '0;
            check       <= 1'b0;
            roundNumber <= '0;
            lastZood    <= '0;
            resultValid <= 1'b0;
            gameWon     <= 1'b0;
            gameLost    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            check       <= 1'b0;
            resultValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (masterLoaded) begin
                        state <= ENTRY;
                    end
                end
                ENTRY: begin
                    guess <= loadedGuess;
                    if (submitGuess && guessComplete) begin
                        state <= CHECK;
                        check <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    state     <= WAIT;
                    waitCount <= '0;
                end
                WAIT: begin
                    if (waitCount == 3'(CHECK_LAT - 1)) begin
                        lastZood    <= Zood;
                        resultValid <= 1'b1;
                        roundNumber <= roundNumber + 4'd1;
                        busy        <= 1'b0;
                        if (Zood == 4'(NUM_SLOTS)) begin
                            gameWon <= 1'b1;
                            state   <= DONE;
                        end else if ((roundNumber + 4'd1) == 4'(MAX_ROUNDS)) begin
                            gameLost <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= ENTRY;
`ifdef AUTO_CLEAR_GUESS_EN
                            guess <= '0;
`else
                            guess <= guess;
`endif
                        end
                    end else begin
                        waitCount <= waitCount + 3'd1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zood_round_controller.sv
// tb_zood_round_controller
// Directed game scenarios with randomized shapes and Zood values.
// Expected outputs come from a slot-level game model kept inside this bench.
module tb_zood_round_controller;

    logic        clock;
    logic        reset;
    logic        masterLoaded;
    logic [2:0]  guessShape;
    logic [1:0]  guessLocation;
    logic        loadGuess;
    logic        submitGuess;
    logic [3:0]  Zood;
    logic [11:0] guess;
    logic        check;
    logic [3:0]  roundNumber;
    logic [3:0]  lastZood;
    logic        resultValid;
    logic        gameWon;
    logic        gameLost;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Game model: four slots plus the game phase and the scoreboard
    int slots[4];
    bit mEntry;
    bit mDone;
    int mRound;
    int mLast;
    bit mWon;
    bit mLost;

    zood_round_controller dut (
        .clock(clock),
        .reset(reset),
        .masterLoaded(masterLoaded),
        .guessShape(guessShape),
        .guessLocation(guessLocation),
        .loadGuess(loadGuess),
        .submitGuess(submitGuess),
        .Zood(Zood),
        .guess(guess),
        .check(check),
        .roundNumber(roundNumber),
        .lastZood(lastZood),
        .resultValid(resultValid),
        .gameWon(gameWon),
        .gameLost(gameLost),
        .busy(busy)
    );

    // Free-running clock with a 10-unit period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] modelGuess();
        logic [11:0] g;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            g[k*3 +: 3] = 3'(slots[k]);
        end
        return g;
    endfunction

    function automatic bit modelFull();
        for (int k = 0; k < 4; k++) begin
            if (slots[k] == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] nonWinZood();
        int z;
        z = int'($urandom_range(0, 14));
        if (z >= 4) z++;
        return 4'(z);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_guess"}, 32'(guess), 32'd0);
        checkOutput({tag, "_check"}, 32'(check), 32'd0);
        checkOutput({tag, "_round"}, 32'(roundNumber), 32'd0);
        checkOutput({tag, "_lastZood"}, 32'(lastZood), 32'd0);
        checkOutput({tag, "_resultValid"}, 32'(resultValid), 32'd0);
        checkOutput({tag, "_won"}, 32'(gameWon), 32'd0);
        checkOutput({tag, "_lost"}, 32'(gameLost), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic doReset();
        reset        = 1'b1;
        masterLoaded = 1'b0;
        loadGuess    = 1'b0;
        submitGuess  = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) slots[k] = 0;
        mEntry = 1'b0;
        mDone  = 1'b0;
        mRound = 0;
        mLast  = 0;
        mWon   = 1'b0;
        mLost  = 1'b0;
        checkIdleOutputs("reset");
    endtask

    task automatic startGame();
        masterLoaded = 1'b1;
        tick();
        mEntry = 1'b1;
    endtask

    // Runs the check/wait/result part of a round and checks it against the model
    task automatic finishRound(input logic [3:0] zoodVal);
        loadGuess     = 1'b1;
        guessLocation = 2'd0;
        guessShape    = 3'b110;
        tick();
        checkOutput("checkOnePulse", 32'(check), 32'd0);
        checkOutput("busyInWait", 32'(busy), 32'd1);
        checkOutput("guessFrozen", 32'(guess), 32'(modelGuess()));
        Zood = zoodVal;
        tick();
        loadGuess = 1'b0;
        Zood      = 4'($urandom);
        mRound++;
        mLast = int'(zoodVal);
        if (int'(zoodVal) == 4) begin
            mWon  = 1'b1;
            mDone = 1'b1;
        end else if (mRound == 8) begin
            mLost = 1'b1;
            mDone = 1'b1;
        end else begin
            mEntry = 1'b1;
`ifdef AUTO_CLEAR_GUESS_EN
            for (int k = 0; k < 4; k++) slots[k] = 0;
`endif
        end
        checkOutput("resultValid", 32'(resultValid), 32'd1);
        checkOutput("lastZood", 32'(lastZood), 32'(mLast));
        checkOutput("roundNumber", 32'(roundNumber), 32'(mRound));
        checkOutput("gameWon", 32'(gameWon), 32'(mWon));
        checkOutput("gameLost", 32'(gameLost), 32'(mLost));
        checkOutput("busyAfter", 32'(busy), 32'd0);
        checkOutput("guessAfter", 32'(guess), 32'(modelGuess()));
        tick();
        checkOutput("resultValidOnce", 32'(resultValid), 32'd0);
        checkOutput("noExtraCheck", 32'(check), 32'd0);
    endtask

    // One cycle of player input; a submit that the model accepts is followed through to its result
    task automatic applyStimulus(input logic [1:0] loc, input logic [2:0] shape, input bit ld, input bit sub,
                                 input logic [3:0] zoodVal);
        bit accepted;
        guessLocation = loc;
        guessShape    = shape;
        loadGuess     = ld;
        submitGuess   = sub;
        tick();
        loadGuess   = 1'b0;
        submitGuess = 1'b0;
        if (mEntry && ld && (shape >= 3'd1) && (shape <= 3'd6)) begin
            slots[loc] = int'(shape);
        end
        accepted = mEntry && sub && modelFull();
        if (accepted) mEntry = 1'b0;
        checkOutput("checkPulse", 32'(check), 32'(accepted));
        checkOutput("busyInCheck", 32'(busy), 32'(accepted));
        checkOutput("guessEntry", 32'(guess), 32'(modelGuess()));
        if (accepted) finishRound(zoodVal);
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k), 3'($urandom_range(1, 6)), 1'b1, 1'b0, 4'd0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        masterLoaded  = 1'b0;
        guessShape    = 3'b000;
        guessLocation = 2'd0;
        loadGuess     = 1'b0;
        submitGuess   = 1'b0;
        Zood          = 4'd0;

        $display("[TB] game 1: first-round win");
        doReset();
        applyStimulus(2'd2, 3'b011, 1'b1, 1'b0, 4'd0);
        startGame();
        for (int k = 0; k < 4; k++) applyStimulus(2'(k), 3'b001, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b1, 4'd4);
        applyStimulus(2'd1, 3'b101, 1'b1, 1'b1, 4'd0);
        checkOutput("doneHoldsWon", 32'(gameWon), 32'd1);

        $display("[TB] game 2: incomplete submit, loads and resubmit");
        doReset();
        startGame();
        for (int k = 0; k < 3; k++) applyStimulus(2'(k), 3'b001, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b1, 4'd0);
        applyStimulus(2'd3, 3'b010, 1'b1, 1'b0, 4'd0);
        checkOutput("directedGuess", 32'(guess), 32'(12'b010001001001));
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b1, 4'd2);
        applyStimulus(2'd0, 3'b000, 1'b0, 1'b1, 4'd3);
        fillRandom();
        applyStimulus(2'd1, 3'b000, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'd2, 3'b111, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'd0, 3'b101, 1'b1, 1'b1, nonWinZood());

        $display("[TB] game 3: eight misses lose the game");
        doReset();
        startGame();
        for (int r = 0; r < 8; r++) begin
            fillRandom();
            applyStimulus(2'd0, 3'b000, 1'b0, 1'b1, nonWinZood());
        end
        applyStimulus(2'd3, 3'b100, 1'b1, 1'b1, 4'd4);
        checkOutput("lostHolds", 32'(gameLost), 32'd1);
        checkOutput("roundHolds", 32'(roundNumber), 32'd8);

        $display("[TB] game 4: win on the final round");
        doReset();
        startGame();
        for (int r = 0; r < 8; r++) begin
            fillRandom();
            applyStimulus(2'd0, 3'b000, 1'b0, 1'b1, (r == 7) ? 4'd4 : nonWinZood());
        end

        $display("[TB] game 5: reset during WAIT");
        doReset();
        startGame();
        fillRandom();
        submitGuess = 1'b1;
        tick();
        submitGuess = 1'b0;
        checkOutput("abortCheck", 32'(check), 32'd1);
        tick();
        reset        = 1'b1;
        masterLoaded = 1'b0;
        Zood         = 4'd4;
        tick();
        reset = 1'b0;
        checkIdleOutputs("abort");
        tick();
        checkOutput("abortNoResult", 32'(resultValid), 32'd0);
        checkOutput("abortRound", 32'(roundNumber), 32'd0);
        for (int k = 0; k < 4; k++) slots[k] = 0;
        mEntry = 1'b0;
        mDone  = 1'b0;
        mRound = 0;
        mLast  = 0;
        mWon   = 1'b0;
        mLost  = 1'b0;
        applyStimulus(2'd1, 3'b011, 1'b1, 1'b1, 4'd0);
        checkOutput("abortWon", 32'(gameWon), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zood_round_controller.md
Name: zood_round_controller

Overview:
- Sits between the player's shape/location switches and the Zood checker, downstream of master-pattern loading.
- Assembles a 12-bit guess one shape at a time and pulses check to the checker.
- Samples the returned Zood count, counts rounds, and declares win or loss.
- Holds the game until masterLoaded is asserted.

Parameters:
NUM_SLOTS, 4, shape slots per pattern; guess width is NUM_SLOTS*3.
MAX_ROUNDS, 8, guesses allowed before loss; range 1..15.
CHECK_LAT, 1, cycles from the check pulse to a valid Zood input; range 1..4.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
masterLoaded  input  1  level; master pattern is complete.
guessShape  input  3  shape code; 001..110 valid, 000/111 invalid.
guessLocation  input  2  slot index; slot k occupies guess[3k+2:3k].
loadGuess  input  1  write guessShape into slot guessLocation.
submitGuess  input  1  request evaluation of the current guess.
Zood  input  4  match count from the checker; 0..NUM_SLOTS.
guess  output  12  assembled guess, driven to the checker.
check  output  1  one-cycle pulse to the checker.
roundNumber  output  4  completed guesses this game.
lastZood  output  4  Zood captured for the most recent round.
resultValid  output  1  one-cycle pulse when lastZood updates.
gameWon  output  1  level; set on a win.
gameLost  output  1  level; set on a loss.
busy  output  1  high in CHECK and WAIT.

Behaviour:
- Reset values: every output is 0, the guess register is 0, and state is IDLE.
- Reset mid-operation (including WAIT) aborts immediately; a late Zood is ignored.
- IDLE: waits for masterLoaded=1, then goes to ENTRY next cycle. Inputs are ignored while in IDLE.
- ENTRY, loading:
  - loadGuess=1 with a valid shape writes that slot at the clock edge; guess reflects it the next cycle.
  - An invalid shape (000/111) is ignored, and the slot is unchanged.
- ENTRY, submitting:
  - submitGuess=1 moves to CHECK only if every slot is nonzero. Otherwise it is ignored and the state stays ENTRY.
  - If loadGuess and submitGuess are both high in the same cycle, the load takes effect first. Completeness is evaluated on the post-load guess.
- CHECK: check=1 for exactly one cycle, then WAIT. The guess is frozen from CHECK through the end of WAIT; loadGuess is ignored.
- WAIT:
  - Counts CHECK_LAT cycles after the check cycle, then samples Zood into lastZood.
  - In that same cycle: pulses resultValid and increments roundNumber.
- WAIT exit conditions:
  - If Zood == NUM_SLOTS, set gameWon and go to DONE.
  - Otherwise, if the incremented roundNumber == MAX_ROUNDS, set gameLost and go to DONE.
  - Otherwise return to ENTRY.
  - A win on the final round takes priority: gameWon=1, gameLost=0.
- Zood out of range: values > NUM_SLOTS are stored in lastZood as-is and treated as no-win.
- roundNumber is 4-bit; it never exceeds MAX_ROUNDS, so it never wraps.
- DONE: gameWon/gameLost, lastZood and roundNumber hold. Submits and loads are ignored. Only reset leaves DONE.
- masterLoaded deasserting outside IDLE has no effect.
- Latency: submit-accepting edge → check high 1 cycle later → resultValid high CHECK_LAT+1 cycles after check.

Optional Feature:
AUTO_CLEAR_GUESS_EN
- Defined: the guess register clears to 0 on the cycle resultValid pulses when returning to ENTRY. The player must re-enter all four slots.
- Undefined: the guess is retained across rounds, so single-slot edits and resubmission are allowed.
- The DONE state always retains the guess in both builds.

Test Plan:
1. Reset, then masterLoaded=1; load slots 0..3 with 001 and submit. Model drives Zood=4 → check pulses once, resultValid after 2 cycles (CHECK_LAT=1), lastZood=4, roundNumber=1, gameWon=1.
2. Load 3 slots only and submit → no check pulse, state ENTRY. Load slot 3 with 010 and submit → check pulses, guess=12'b010001001001.
3. Loads with shape 000 and 111 → guess unchanged. Simultaneous load (slot 0, 101) and submit on a full guess → check fires with slot 0 = 101.
4. Eight submits with Zood=1 → roundNumber steps 1..8, gameLost=1 after the 8th, then a 9th submit produces no check. Repeat with Zood=4 on round 8 → gameWon=1, gameLost=0.
5. Assert reset during WAIT, with Zood=4 presented on the following cycle → all outputs 0, state IDLE, no resultValid.
6. With AUTO_CLEAR_GUESS_EN, Zood=2 result → guess=0 in ENTRY. Without it → guess is unchanged, and an immediate resubmit pulses check.
